// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the AES job scheduler.
// Optional key cache is enabled by defining AES_KEY_CACHE_EN.
package aes_sched_pkg;

   localparam int unsigned BLOCK_W = 128;
   localparam int unsigned WDOG_W  = 8;

   typedef logic [BLOCK_W-1:0] block_t;
   typedef logic [WDOG_W-1:0]  wdog_t;

   typedef enum logic [2:0] {
      StIdle,
      StKeyld,
      StStart,
      StBusy,
      StResp
   } sched_state_e;

   // Port index (0/1) to one-hot requester select.
   function automatic logic [1:0] port_onehot(input logic port);
      return port ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with a one-bit priority pointer.
module rr_arbiter2 (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant
);

   logic ptr_q;

   always_comb begin
      grant = 2'b00;
      unique case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
         default: grant = 2'b00;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         ptr_q <= 1'b0;
      end else if (advance && (grant != 2'b00)) begin
         // The winner yields priority to the other port.
         ptr_q <= grant[0];
      end
   end

endmodule

// File: rtl/aes_job_scheduler.sv
// Shares one AES core between two requesters: round-robin grant, key load/start sequencing,
// watchdog abort and result return. Define AES_KEY_CACHE_EN to skip reloading a repeated key.
module aes_job_scheduler
   import aes_sched_pkg::*;
#(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         io_req0_valid,
   output logic         io_req0_ready,
   input  logic [127:0] io_req0_key,
   input  logic [127:0] io_req0_data,
   input  logic         io_req0_decrypt,
   input  logic         io_req1_valid,
   output logic         io_req1_ready,
   input  logic [127:0] io_req1_key,
   input  logic [127:0] io_req1_data,
   input  logic         io_req1_decrypt,
   output logic         io_rsp0_valid,
   input  logic         io_rsp0_ready,
   output logic         io_rsp1_valid,
   input  logic         io_rsp1_ready,
   output logic [127:0] io_rsp_data,
   output logic         io_rsp_err,
   output logic [127:0] io_core_key,
   output logic [127:0] io_core_data,
   output logic         io_core_decrypt,
   output logic         io_core_key_load,
   output logic         io_core_start,
   output logic         io_core_abort,
   input  logic         io_core_done,
   input  logic [127:0] io_core_result
);

   localparam wdog_t TimeoutLim = WDOG_W'(TIMEOUT);

   sched_state_e state_q;
   logic         owner_q;
   block_t       key_q, data_q, rsp_data_q;
   logic         decrypt_q;
   logic         key_load_q, start_q, abort_q;
   logic [1:0]   rsp_valid_q;
   logic         rsp_err_q;
   wdog_t        wdog_q;

   logic [1:0]   req;
   logic [1:0]   grant;
   logic         is_idle;
   logic         advance;
   logic         sel_port;
   block_t       sel_key, sel_data;
   logic         sel_decrypt;
   logic         cache_hit;
   wdog_t        wdog_inc;
   logic         done_evt;
   logic         timeout_evt;
   logic         rsp_fire;

   assign req     = {io_req1_valid, io_req0_valid};
   assign is_idle = (state_q == StIdle);
   assign advance = is_idle && (req != 2'b00);

   rr_arbiter2 u_arb (
      .clock   (clock),
      .reset   (reset),
      .req     (req),
      .advance (advance),
      .grant   (grant)
   );

   // Ready is a pure IDLE-state acknowledge; suppressed while reset is held.
   assign io_req0_ready = reset && is_idle && grant[0];
   assign io_req1_ready = reset && is_idle && grant[1];

   assign sel_port    = grant[1];
   assign sel_key     = sel_port ? io_req1_key     : io_req0_key;
   assign sel_data    = sel_port ? io_req1_data    : io_req0_data;
   assign sel_decrypt = sel_port ? io_req1_decrypt : io_req0_decrypt;

   assign wdog_inc    = wdog_q + WDOG_W'(1);
   assign done_evt    = (state_q == StBusy) && io_core_done;
   // Done in the same cycle as expiry takes priority over the abort.
   assign timeout_evt = (state_q == StBusy) && !io_core_done && (wdog_inc == TimeoutLim);
   assign rsp_fire    = (rsp_valid_q & {io_rsp1_ready, io_rsp0_ready}) != 2'b00;

`ifdef AES_KEY_CACHE_EN
   block_t cache_key_q;
   logic   cache_valid_q;

   always_ff @(posedge clock) begin
      if (!reset) begin
         cache_key_q   <= '0;
         cache_valid_q <= 1'b0;
      end else if (timeout_evt) begin
         cache_valid_q <= 1'b0;
      end else if (state_q == StKeyld) begin
         cache_key_q   <= key_q;
         cache_valid_q <= 1'b1;
      end
   end

   assign cache_hit = cache_valid_q && (cache_key_q == sel_key);
`else
   assign cache_hit = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= StIdle;
         owner_q     <= 1'b0;
         key_q       <= '0;
         data_q      <= '0;
         decrypt_q   <= 1'b0;
         key_load_q  <= 1'b0;
         start_q     <= 1'b0;
         abort_q     <= 1'b0;
         rsp_valid_q <= 2'b00;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         wdog_q      <= '0;
      end else begin
         key_load_q <= 1'b0;
         start_q    <= 1'b0;
         abort_q    <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (req != 2'b00) begin
                  owner_q   <= sel_port;
                  key_q     <= sel_key;
                  data_q    <= sel_data;
                  decrypt_q <= sel_decrypt;
                  if (cache_hit) begin
                     start_q <= 1'b1;
                     state_q <= StStart;
                  end else begin
                     key_load_q <= 1'b1;
                     state_q    <= StKeyld;
                  end
               end
            end
            StKeyld: begin
               start_q <= 1'b1;
               state_q <= StStart;
            end
            StStart: begin
               wdog_q  <= '0;
               state_q <= StBusy;
            end
            StBusy: begin
               wdog_q <= wdog_inc;
               if (done_evt) begin
                  rsp_data_q  <= io_core_result;
                  rsp_err_q   <= 1'b0;
                  rsp_valid_q <= port_onehot(owner_q);
                  state_q     <= StResp;
               end else if (timeout_evt) begin
                  abort_q     <= 1'b1;
                  rsp_data_q  <= '0;
                  rsp_err_q   <= 1'b1;
                  rsp_valid_q <= port_onehot(owner_q);
                  state_q     <= StResp;
               end
            end
            StResp: begin
               if (rsp_fire) begin
                  rsp_valid_q <= 2'b00;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign io_rsp0_valid    = rsp_valid_q[0];
   assign io_rsp1_valid    = rsp_valid_q[1];
   assign io_rsp_data      = rsp_data_q;
   assign io_rsp_err       = rsp_err_q;
   assign io_core_key      = key_q;
   assign io_core_data     = data_q;
   assign io_core_decrypt  = decrypt_q;
   assign io_core_key_load = key_load_q;
   assign io_core_start    = start_q;
   assign io_core_abort    = abort_q;

endmodule

// File: tb/tb_aes_job_scheduler.sv
// Directed bench for aes_job_scheduler: vector table of jobs plus reset/idle-done sequences.
// Expectations adapt to AES_KEY_CACHE_EN when that macro is defined.
module tb_aes_job_scheduler;

   localparam int unsigned TO = 16;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic         io_req0_valid = 1'b0, io_req1_valid = 1'b0;
   logic         io_req0_ready, io_req1_ready;
   logic [127:0] io_req0_key = '0, io_req1_key = '0, io_req0_data = '0, io_req1_data = '0;
   logic         io_req0_decrypt = 1'b0, io_req1_decrypt = 1'b0;
   logic         io_rsp0_valid, io_rsp1_valid;
   logic         io_rsp0_ready = 1'b0, io_rsp1_ready = 1'b0;
   logic [127:0] io_rsp_data;
   logic         io_rsp_err;
   logic [127:0] io_core_key, io_core_data;
   logic         io_core_decrypt, io_core_key_load, io_core_start, io_core_abort;
   logic         io_core_done = 1'b0;
   logic [127:0] io_core_result = '0;

   aes_job_scheduler #(.TIMEOUT(TO)) dut (
      .clock           (clock),
      .reset           (reset),
      .io_req0_valid   (io_req0_valid),
      .io_req0_ready   (io_req0_ready),
      .io_req0_key     (io_req0_key),
      .io_req0_data    (io_req0_data),
      .io_req0_decrypt (io_req0_decrypt),
      .io_req1_valid   (io_req1_valid),
      .io_req1_ready   (io_req1_ready),
      .io_req1_key     (io_req1_key),
      .io_req1_data    (io_req1_data),
      .io_req1_decrypt (io_req1_decrypt),
      .io_rsp0_valid   (io_rsp0_valid),
      .io_rsp0_ready   (io_rsp0_ready),
      .io_rsp1_valid   (io_rsp1_valid),
      .io_rsp1_ready   (io_rsp1_ready),
      .io_rsp_data     (io_rsp_data),
      .io_rsp_err      (io_rsp_err),
      .io_core_key     (io_core_key),
      .io_core_data    (io_core_data),
      .io_core_decrypt (io_core_decrypt),
      .io_core_key_load(io_core_key_load),
      .io_core_start   (io_core_start),
      .io_core_abort   (io_core_abort),
      .io_core_done    (io_core_done),
      .io_core_result  (io_core_result)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [1:0]   mask;     // request valids {1,0}
      int           port;     // expected winner
      logic [127:0] key;
      logic [127:0] data;
      logic         dec;
      int           d;        // done this many cycles after start; 0 = never
      logic [127:0] result;
      int           hold;     // cycles rsp_ready stays low
      logic         exp_err;
      logic [127:0] exp_rsp;
   } vec_t;

   int tests = 0;
   int fails = 0;
   logic         cache_v = 1'b0;
   logic [127:0] cache_k = '0;
   vec_t vecs[8];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic run_job(input int i, input vec_t v);
      logic [1:0] oh;
      logic       kl_exp;
      int         exp_n, got, aborts;
      oh = (v.port == 1) ? 2'b10 : 2'b01;
      io_req0_valid   = v.mask[0];
      io_req1_valid   = v.mask[1];
      io_req0_key     = (v.port == 0) ? v.key : ~v.key;
      io_req1_key     = (v.port == 1) ? v.key : ~v.key;
      io_req0_data    = (v.port == 0) ? v.data : ~v.data;
      io_req1_data    = (v.port == 1) ? v.data : ~v.data;
      io_req0_decrypt = (v.port == 0) ? v.dec : ~v.dec;
      io_req1_decrypt = (v.port == 1) ? v.dec : ~v.dec;
      #1;
      check($sformatf("v%0d ready", i), {126'd0, io_req1_ready, io_req0_ready}, {126'd0, oh});
`ifdef AES_KEY_CACHE_EN
      kl_exp = !(cache_v && cache_k == v.key);
`else
      kl_exp = 1'b1;
`endif
      // Cycle T+1: operands must already be latched; scramble requester inputs.
      @(negedge clock);
      io_req0_valid = 1'b0;
      io_req1_valid = 1'b0;
      io_req0_key = rnd128(); io_req1_key = rnd128();
      io_req0_data = rnd128(); io_req1_data = rnd128();
      #1;
      check($sformatf("v%0d key_load", i), {127'd0, io_core_key_load}, {127'd0, kl_exp});
      check($sformatf("v%0d core_key", i), io_core_key, v.key);
      check($sformatf("v%0d core_data", i), io_core_data, v.data);
      check($sformatf("v%0d core_dec", i), {127'd0, io_core_decrypt}, {127'd0, v.dec});
      if (kl_exp) begin
         cache_k = v.key;
         cache_v = 1'b1;
         @(negedge clock);
         #1;
         check($sformatf("v%0d kl_drop", i), {127'd0, io_core_key_load}, 128'd0);
      end
      check($sformatf("v%0d start", i), {127'd0, io_core_start}, 128'd1);
      exp_n  = (v.d >= 1 && v.d <= int'(TO)) ? v.d + 1 : int'(TO) + 1;
      got    = 0;
      aborts = 0;
      for (int n = 1; n <= int'(TO) + 4 && got == 0; n++) begin
         @(negedge clock);
         io_core_done   = (n == v.d);
         io_core_result = (n == v.d) ? v.result : rnd128();
         #1;
         if (io_core_abort) aborts++;
         if (io_rsp0_valid || io_rsp1_valid) got = n;
      end
      io_core_done = 1'b0;
      if (v.exp_err) cache_v = 1'b0;
      check($sformatf("v%0d rsp_latency", i), 128'(got), 128'(exp_n));
      check($sformatf("v%0d rsp_valid", i), {126'd0, io_rsp1_valid, io_rsp0_valid}, {126'd0, oh});
      check($sformatf("v%0d rsp_data", i), io_rsp_data, v.exp_rsp);
      check($sformatf("v%0d rsp_err", i), {127'd0, io_rsp_err}, {127'd0, v.exp_err});
      check($sformatf("v%0d aborts", i), 128'(aborts), {127'd0, v.exp_err});
      // Stray done pulses in RESP must not disturb the held response.
      for (int h = 0; h < v.hold; h++) begin
         @(negedge clock);
         io_core_done   = 1'b1;
         io_core_result = rnd128();
         #1;
         check($sformatf("v%0d hold_data", i), io_rsp_data, v.exp_rsp);
         check($sformatf("v%0d hold_valid", i), {126'd0, io_rsp1_valid, io_rsp0_valid},
               {126'd0, oh});
         check($sformatf("v%0d hold_abort", i), {127'd0, io_core_abort}, 128'd0);
      end
      @(negedge clock);
      io_core_done  = 1'b0;
      io_rsp0_ready = (v.port == 0);
      io_rsp1_ready = (v.port == 1);
      io_req0_valid = 1'b1;
      io_req1_valid = 1'b1;
      #1;
      check($sformatf("v%0d no_grant_in_hs", i), {126'd0, io_req1_ready, io_req0_ready}, 128'd0);
      @(negedge clock);
      io_rsp0_ready = 1'b0;
      io_rsp1_ready = 1'b0;
      io_req0_valid = 1'b0;
      io_req1_valid = 1'b0;
      #1;
      check($sformatf("v%0d rsp_cleared", i), {126'd0, io_rsp1_valid, io_rsp0_valid}, 128'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " strobes"}, {125'd0, io_core_key_load, io_core_start, io_core_abort}, 128'd0);
      check({tag, " rsp_valid"}, {126'd0, io_rsp1_valid, io_rsp0_valid}, 128'd0);
      check({tag, " rsp_data"}, io_rsp_data, 128'd0);
      check({tag, " rsp_err"}, {127'd0, io_rsp_err}, 128'd0);
      check({tag, " core_key"}, io_core_key, 128'd0);
      check({tag, " core_data"}, io_core_data, 128'd0);
      check({tag, " core_dec"}, {127'd0, io_core_decrypt}, 128'd0);
      check({tag, " ready"}, {126'd0, io_req1_ready, io_req0_ready}, 128'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      logic [127:0] k0, k1, k2;
      k0 = 128'h000102030405060708090a0b0c0d0e0f;
      k1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      k2 = 128'hffeeddccbbaa99887766554433221100;
      vecs[0] = '{2'b11, 0, k0, 128'h00112233445566778899aabbccddeeff, 1'b0, 10,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0,
                  1'b0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
      vecs[1] = '{2'b11, 1, k0, 128'hdeadbeef0badf00dcafebabe12345678, 1'b0, 3,
                  128'h0123456789abcdeffedcba9876543210, 2,
                  1'b0, 128'h0123456789abcdeffedcba9876543210};
      vecs[2] = '{2'b11, 0, k1, 128'h6bc1bee22e409f96e93d7e117393172a, 1'b0, 1,
                  128'h3ad77bb40d7a3660a89ecaf32466ef97, 1,
                  1'b0, 128'h3ad77bb40d7a3660a89ecaf32466ef97};
      vecs[3] = '{2'b11, 1, k1, 128'h3ad77bb40d7a3660a89ecaf32466ef97, 1'b1, 5,
                  128'h6bc1bee22e409f96e93d7e117393172a, 0,
                  1'b0, 128'h6bc1bee22e409f96e93d7e117393172a};
      vecs[4] = '{2'b01, 0, k1, 128'h55555555aaaaaaaa55555555aaaaaaaa, 1'b1, 7,
                  128'h11111111222222223333333344444444, 0,
                  1'b0, 128'h11111111222222223333333344444444};
      vecs[5] = '{2'b10, 1, k2, 128'h0f0e0d0c0b0a09080706050403020100, 1'b0, 2,
                  128'ha5a5a5a55a5a5a5aa5a5a5a55a5a5a5a, 0,
                  1'b0, 128'ha5a5a5a55a5a5a5aa5a5a5a55a5a5a5a};
      vecs[6] = '{2'b01, 0, k2, 128'hcafef00dcafef00dcafef00dcafef00d, 1'b0, 0,
                  128'h0, 1, 1'b1, 128'h0};
      vecs[7] = '{2'b11, 1, k2, 128'h13579bdf2468ace013579bdf2468ace0, 1'b0, int'(TO),
                  128'hfeedfacefeedfacefeedfacefeedface, 0,
                  1'b0, 128'hfeedfacefeedfacefeedfacefeedface};

      repeat (2) @(negedge clock);
      #1;
      check_all_zero("reset");
      @(negedge clock);
      reset = 1'b1;
      #1;
      check_all_zero("post_reset_idle");

      for (int i = 0; i < 8; i++) run_job(i, vecs[i]);

      // Done pulse in IDLE is ignored.
      @(negedge clock);
      io_core_done   = 1'b1;
      io_core_result = rnd128();
      @(negedge clock);
      io_core_done = 1'b0;
      #1;
      check("idle_done rsp_valid", {126'd0, io_rsp1_valid, io_rsp0_valid}, 128'd0);
      check("idle_done start", {127'd0, io_core_start}, 128'd0);

      // Reset in BUSY: pointer returns to port 0, cache (if any) forgotten.
      @(negedge clock);
      io_req0_valid = 1'b1;
      io_req0_key   = k0;
      io_req0_data  = 128'h1;
      #1;
      check("rbusy grant", {126'd0, io_req1_ready, io_req0_ready}, 128'd1);
      @(negedge clock);
      io_req0_valid = 1'b0;
      repeat (5) @(negedge clock);
      #1;
      check("rbusy pending", {126'd0, io_rsp1_valid, io_rsp0_valid}, 128'd0);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      #1;
      check_all_zero("rbusy");
      io_req0_valid = 1'b1;
      io_req1_valid = 1'b1;
      io_req1_key   = k0;
      #1;
      check("rbusy regrant", {126'd0, io_req1_ready, io_req0_ready}, 128'd1);
      @(negedge clock);
      io_req0_valid = 1'b0;
      io_req1_valid = 1'b0;
      #1;
      check("rbusy key_load", {127'd0, io_core_key_load}, 128'd1);
      check("rbusy core_key", io_core_key, k0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/aes_job_scheduler.md
# aes_job_scheduler

Shares the single `aes` core between two requester ports (host-side Wishbone bridge on port 0, bulk/streaming client on port 1). Arbitrates round-robin, sequences the core through key load, start and completion, then returns the 128-bit result to the owning requester. A watchdog aborts hung operations. Sits between the Wishbone register front-end and the `aes` datapath inside `user_project_wrapper`.

## Interface
- `TIMEOUT`, 64, max cycles in BUSY before abort; legal 2..255
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-low
- `io_req0_valid` / `io_req1_valid`  in  1  request present
- `io_req0_ready` / `io_req1_ready`  out  1  request accepted this cycle
- `io_req0_key` / `io_req1_key`  in  128  cipher key
- `io_req0_data` / `io_req1_data`  in  128  input block
- `io_req0_decrypt` / `io_req1_decrypt`  in  1  1 = decrypt, 0 = encrypt
- `io_rsp0_valid` / `io_rsp1_valid`  out  1  result available
- `io_rsp0_ready` / `io_rsp1_ready`  in  1  requester takes result
- `io_rsp_data`  out  128  result block (shared; qualified by rsp valids)
- `io_rsp_err`  out  1  1 = operation timed out, data forced to 0
- `io_core_key`, `io_core_data`  out  128  latched operands to core
- `io_core_decrypt`  out  1  latched mode
- `io_core_key_load`  out  1  one-cycle key load strobe
- `io_core_start`  out  1  one-cycle start strobe
- `io_core_abort`  out  1  one-cycle abort strobe on timeout
- `io_core_done`  in  1  one-cycle completion pulse
- `io_core_result`  in  128  valid in the `io_core_done` cycle

## Operation
- States: IDLE, KEYLD, START, BUSY, RESP.
- IDLE: if any req valid, grant one: `io_reqN_ready`=1 combinationally for granted N only; latch key, data, decrypt, owner. Next state KEYLD (START on cache hit, see Configuration).
- Arbitration: round-robin pointer; both valid -> pointer's port wins; single valid -> that port. Pointer moves to the other port after every grant.
- KEYLD: `io_core_key_load`=1 one cycle -> START.
- START: `io_core_start`=1 one cycle, clear watchdog -> BUSY.
- BUSY: watchdog increments each cycle. `io_core_done` -> latch result, err=0 -> RESP. Watchdog reaches TIMEOUT without done -> `io_core_abort`=1 one cycle, data=0, err=1 -> RESP. Done and timeout same cycle: done wins.
- RESP: `io_rspN_valid`=1 for owner only, data/err stable until `io_rspN_ready`; on handshake -> IDLE. No new grant in the handshake cycle.
- `io_core_done` outside BUSY ignored. Requester changing operands after grant has no effect (latched).
- Core operands held stable from grant until next grant.

## Timing
- Reset (reset=0 at edge): state IDLE, all strobes 0, ready/valid 0, `io_rsp_data`=0, `io_rsp_err`=0, core operands 0, pointer=port 0, watchdog 0, key cache invalid. Applies mid-operation; no abort strobe issued.
- Grant at cycle T: key_load T+1, start T+2, BUSY from T+3. Cache hit: start T+1, BUSY from T+2.
- Done at cycle D -> rsp valid at D+1. Timeout: abort strobe and rsp valid in the cycle after the watchdog hits TIMEOUT.
- Minimum gap between grants: response handshake cycle + 1.

## Configuration
- `AES_KEY_CACHE_EN` defined: scheduler stores last loaded key (128 b + valid bit). Grant with key equal to stored key and valid -> skip KEYLD, go straight to START. Cache invalidated by reset and by any timeout.
- Undefined: every job passes through KEYLD; no key storage.

## Structure
- Package `aes_sched_pkg`: state enum, `BLOCK_W`=128, watchdog width constant (8).
- Sub-module `rr_arbiter2`: two requests, pointer register, one-hot grant, `advance` input.
- Scheduler FSM, operand/result registers, watchdog and optional key cache in `aes_job_scheduler`.

## Test plan
- Single encrypt on port 0, key 0x000102..0F, data 0x00112233..FF, core done 10 cycles after start, result 0x69C4E0D8..C55A -> key_load T+1, start T+2, `io_rsp0_valid` at done+1 with that data, err=0, `io_rsp1_valid` never high.
- Both ports valid in IDLE after reset -> port 0 granted; both valid again -> port 1 granted; sequence alternates 0,1,0,1 over four jobs.
- Core never asserts done, TIMEOUT=16 -> abort strobe once after 16 BUSY cycles, owner rsp valid with data 0, err=1.
- Done and timeout coincide -> err=0, result returned, no abort strobe.
- With `AES_KEY_CACHE_EN`: two jobs same key -> second has no key_load, start at T+1; after a timeout, same key reloads. Without macro: key_load on every job.
- Reset asserted in BUSY with rsp_ready held low -> next cycle all outputs 0, IDLE; next request granted from port 0 with full key load.
